config_chain_loader: RTL and testbench
======================================

// Module: config_chain_loader
// PURPOSE
//  Drives the serial configuration chain of a PE block (config_in -> ... -> config_out).
//  Accepts the bitstream as WORD_W-bit words on a valid/ready port and shifts it out one bit per cycle.
//  Optionally re-shifts the same stream while checking the bits returned on the chain's config_out.
//  Sits at the array top, clocked by config_clk, ahead of the first config_cell of the chain.
// PARAMETERS
//  CHAIN_LEN  12  total config bits in the attached chain (>=1)
//  WORD_W     32  width of bitstream input words (matches datapath size)
// PORTS
//  config_clk    in   1          configuration clock; all state on rising edge
//  config_reset  in   1          synchronous, active-low reset
//  start         in   1          1-cycle pulse: begin a load; ignored while busy
//  verify_en     in   1          sampled with start: 1 = run readback pass after load
//  word_data     in   WORD_W     bitstream word, bit 0 shifted first
//  word_valid    in   1          word_data valid
//  word_ready    out  1          loader accepts word_data this cycle
//  cfg_bit       out  1          serial bit to chain config_in
//  cfg_shift     out  1          clock-enable for the chain; chain shifts on edges where 1
//  cfg_ret       in   1          chain config_out (last cell), for readback
//  busy          out  1          high in LOAD and VERIFY
//  done          out  1          1-cycle pulse when sequence completes
//  err           out  1          sticky readback mismatch flag
// BEHAVIOUR
//  - Reset (config_reset==0 at edge): state IDLE; word_ready, cfg_bit, cfg_shift, busy, done, err = 0;
//    counters and capture buffer cleared. Reset mid-load aborts; chain content is then undefined.
//  - States: IDLE -> LOAD on start. LOAD -> VERIFY (verify_en latched 1) or DONE after CHAIN_LEN bits
//    shifted. VERIFY -> DONE after CHAIN_LEN bits. DONE -> IDLE next cycle (done=1 only in DONE).
//  - start in IDLE clears err and all counters; start while busy/DONE has no effect.
//  - LOAD: word_ready = 1 only when holding register empty and bits_sent < CHAIN_LEN.
//    Word accepted on edge with word_valid & word_ready; its bits emitted on the following cycles,
//    bit 0 first, cfg_shift=1 for each; one bubble cycle (cfg_shift=0) between words.
//  - Word count = ceil(CHAIN_LEN/WORD_W); last word supplies only the remaining bits, upper bits ignored.
//  - Each shifted bit is also written to a CHAIN_LEN-bit capture buffer at index bits_sent.
//  - word_valid low: loader waits with cfg_shift=0; no timeout.
//  - cfg_bit holds its last value when cfg_shift=0 (don't-care for chain).
//  - VERIFY: for i = 0..CHAIN_LEN-1, cfg_bit = buffer[i], cfg_shift=1 every cycle (no bubbles);
//    on same edge compare cfg_ret with buffer[i]; mismatch sets err (sticky until next start).
//    Chain ends holding the same content as after LOAD.
//  - Latency: no-verify total = CHAIN_LEN + words (bubbles) cycles after first accept; verify adds CHAIN_LEN.
//  - word_ready = 0 outside LOAD; extra words offered after the last are not consumed.
// TESTING
//  - CHAIN_LEN=12,WORD_W=8, words 0xA5,0x03, verify_en=0 -> cfg_bit seq 1,0,1,0,0,1,0,1,1,1,0,0; 12 shifts; done 1 pulse.
//  - Same with verify_en=1 and 12-bit shift-register model on cfg_ret -> 12 more shifts, same seq, err=0.
//  - Verify with model bit 5 forced inverted -> err=1 after DONE; next start clears err to 0.
//  - word_valid stalled 5 cycles between words -> cfg_shift=0 during stall, stream unchanged, word_ready held 1.
//  - config_reset low mid-LOAD (after 6 bits) -> next cycle all outputs 0, IDLE; new start reloads full 12 bits.
//  - start pulsed during LOAD/VERIFY and in DONE -> ignored; CHAIN_LEN=1 -> one word, one shift, done.

Source files
------------

// File: rtl/config_chain_loader.sv
// Serial configuration chain loader.
// Takes the bitstream as WORD_W-bit words on a valid/ready port and shifts it into a PE config
// chain one bit per cycle, bit 0 first. An optional second pass re-shifts the captured stream
// and compares the bits that come back out of the end of the chain.
module config_chain_loader #(
  parameter int unsigned CHAIN_LEN = 12,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              config_clk,
  input  logic              config_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_bit,
  output logic              cfg_shift,
  input  logic              cfg_ret,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned HoldW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    hold_q, hold_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [CntW-1:0]      bits_sent_q, bits_sent_d;
  logic [CntW-1:0]      vidx_q, vidx_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic                 verify_q, verify_d;
  logic                 err_q, err_d;
  logic                 last_bit_q, last_bit_d;
  logic [31:0]          remain;
  logic [31:0]          take;

  // Bits the next accepted word contributes: a full word, or only what is left of the chain.
  always_comb begin
    remain = CHAIN_LEN - 32'(bits_sent_q);
    take   = (remain < WORD_W) ? remain : WORD_W;
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    bits_sent_d = bits_sent_q;
    vidx_d      = vidx_q;
    cap_d       = cap_q;
    verify_d    = verify_q;
    err_d       = err_q;
    last_bit_d  = last_bit_q;
    word_ready  = 1'b0;
    cfg_shift   = 1'b0;
    cfg_bit     = last_bit_q;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          verify_d    = verify_en;
          err_d       = 1'b0;
          bits_sent_d = '0;
          vidx_d      = '0;
          hold_cnt_d  = '0;
          cap_d       = '0;
        end
      end

      StLoad: begin
        busy = 1'b1;
        if (hold_cnt_q != '0) begin
          // Emit the next bit of the held word and record it for readback.
          cfg_shift              = 1'b1;
          cfg_bit                = hold_q[0];
          last_bit_d             = hold_q[0];
          cap_d[bits_sent_q]     = hold_q[0];
          hold_d                 = hold_q >> 1;
          hold_cnt_d             = hold_cnt_q - HoldW'(1);
          bits_sent_d            = bits_sent_q + CntW'(1);
          if (bits_sent_q == CntW'(CHAIN_LEN - 1)) begin
            state_d = verify_q ? StVerify : StDone;
          end
        end else begin
          // Empty holding register: this is the bubble cycle between words.
          word_ready = (32'(bits_sent_q) < CHAIN_LEN);
          if (word_valid && word_ready) begin
            hold_d     = word_data;
            hold_cnt_d = HoldW'(take);
          end
        end
      end

      StVerify: begin
        busy       = 1'b1;
        cfg_shift  = 1'b1;
        cfg_bit    = cap_q[vidx_q];
        last_bit_d = cap_q[vidx_q];
        // The bit leaving the chain now is the one that entered CHAIN_LEN shifts ago.
        if (cfg_ret != cap_q[vidx_q]) begin
          err_d = 1'b1;
        end
        vidx_d = vidx_q + CntW'(1);
        if (vidx_q == CntW'(CHAIN_LEN - 1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    err = err_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge config_clk) begin
    if (!config_reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      bits_sent_q <= '0;
      vidx_q      <= '0;
      cap_q       <= '0;
      verify_q    <= 1'b0;
      err_q       <= 1'b0;
      last_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      bits_sent_q <= bits_sent_d;
      vidx_q      <= vidx_d;
      cap_q       <= cap_d;
      verify_q    <= verify_d;
      err_q       <= err_d;
      last_bit_q  <= last_bit_d;
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: randomized loads checked against a bitstream/chain reference.
module tb_config_chain_loader;

  localparam int unsigned CL = 12;
  localparam int unsigned WW = 8;
  localparam int unsigned NW = (CL + WW - 1) / WW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          config_reset;
  logic          start, verify_en, word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready, cfg_bit, cfg_shift, cfg_ret, busy, done, err;

  logic          s1_start, s1_ver, s1_valid;
  logic [WW-1:0] s1_data;
  logic          ready1, bit1, shift1, ret1, busy1, done1, err1;

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
    .config_clk  (clk),
    .config_reset(config_reset),
    .start       (start),
    .verify_en   (verify_en),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .cfg_bit     (cfg_bit),
    .cfg_shift   (cfg_shift),
    .cfg_ret     (cfg_ret),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  config_chain_loader #(.CHAIN_LEN(1), .WORD_W(WW)) u_dut1 (
    .config_clk  (clk),
    .config_reset(config_reset),
    .start       (s1_start),
    .verify_en   (s1_ver),
    .word_data   (s1_data),
    .word_valid  (s1_valid),
    .word_ready  (ready1),
    .cfg_bit     (bit1),
    .cfg_shift   (shift1),
    .cfg_ret     (ret1),
    .busy        (busy1),
    .done        (done1),
    .err         (err1)
  );

  // Chain models: plain shift registers clocked by cfg_shift; optional fault on one returned bit.
  logic [CL-1:0] chain = '0;
  logic          chain1 = 1'b0;
  int            nshift = 0;
  logic          clr = 1'b0;
  logic          inj = 1'b0;

  always @(posedge clk) begin
    if (cfg_shift) chain <= {chain[CL-2:0], cfg_bit};
    if (shift1) chain1 <= bit1;
    if (clr) nshift <= 0;
    else if (cfg_shift) nshift <= nshift + 1;
  end

  assign cfg_ret = chain[CL-1] ^ (inj && (nshift == CL + 5));
  assign ret1    = chain1;

  int nvec = 0;
  int nerr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_load(input bit fixed, input bit ver, input bit do_inj, input int stall);
    logic [WW-1:0] words[NW];
    bit            expb[$];
    bit            seen[$];
    logic [CL-1:0] exp_chain;
    int            k, cyc, done_cyc, ndone, stall_left;
    bit            offered, started, ready_seen, extra_bad, stall_bad, hold_bad;
    logic          last;
    for (int w = 0; w < int'(NW); w++) words[w] = WW'($urandom);
    if (fixed) begin
      words[0] = 8'hA5;
      words[1] = 8'h03;
    end
    for (int i = 0; i < int'(CL); i++) begin
      expb.push_back(words[i / WW][i % WW]);
      exp_chain[CL-1-i] = words[i / WW][i % WW];
    end
    inj = do_inj;
    clr = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    start     = 1'b1;
    verify_en = ver;
    @(negedge clk);
    start     = 1'b0;
    verify_en = 1'($urandom);
    check_eq("start_busy_err", {30'd0, busy, err}, 32'd2);

    k = 0; cyc = 0; done_cyc = -1; ndone = 0; stall_left = 0;
    offered = 0; started = 0; ready_seen = 0; extra_bad = 0; stall_bad = 0; hold_bad = 0;
    last = cfg_bit;
    for (int t = 0; t < 400 && ndone == 0; t++) begin
      if (offered) begin
        k++;
        if (k == 1) started = 1;
        stall_left = stall;
        ready_seen = 0;
      end
      if (started) cyc++;
      if (cfg_shift) begin
        seen.push_back(cfg_bit);
        last = cfg_bit;
      end else if (cfg_bit !== last) begin
        hold_bad = 1;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      offered = 0;
      start   = 1'b0;
      if (k < int'(NW)) begin
        if (k > 0 && stall_left > 0) begin
          word_valid = 1'b0;
          if (word_ready) begin
            ready_seen = 1;
            stall_left--;
            if (cfg_shift) stall_bad = 1;
          end else if (ready_seen) begin
            stall_bad = 1;
          end
        end else begin
          word_valid = 1'b1;
          word_data  = words[k];
          offered    = word_ready;
        end
      end else begin
        word_valid = 1'($urandom);
        word_data  = WW'($urandom);
        if (word_ready) extra_bad = 1;
      end
      // Stray start pulses while busy and in the DONE cycle must be ignored.
      if ((busy && $urandom_range(0, 3) == 0) || done) begin
        start     = 1'b1;
        verify_en = 1'($urandom);
      end
      @(negedge clk);
    end
    start      = 1'b0;
    word_valid = 1'b0;
    check_eq("done_pulses", 32'(ndone), 32'd1);
    check_eq("idle_after_done", {28'd0, busy, done, word_ready, cfg_shift}, 32'd0);
    @(negedge clk);
    check_eq("still_idle", {29'd0, busy, done, cfg_shift}, 32'd0);
    check_eq("shift_count", 32'(seen.size()), ver ? 2 * CL : CL);
    for (int i = 0; i < seen.size() && i < int'(2 * CL); i++) begin
      check_eq($sformatf("bit%0d", i), 32'(seen[i]), 32'(expb[i % CL]));
    end
    check_eq("latency", 32'(done_cyc), CL + NW + stall * (NW - 1) + (ver ? CL : 0));
    check_eq("err", 32'(err), 32'(do_inj && ver));
    check_eq("chain", 32'(chain), 32'(exp_chain));
    check_eq("extra_word", 32'(extra_bad), 32'd0);
    check_eq("stall", 32'(stall_bad), 32'd0);
    check_eq("bit_hold", 32'(hold_bad), 32'd0);
    inj = 1'b0;
  endtask

  task automatic reset_mid_load();
    clr = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    start     = 1'b1;
    verify_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 100 && nshift < 6; t++) begin
      word_valid = 1'b1;
      word_data  = WW'($urandom);
      @(negedge clk);
    end
    check_eq("pre_reset_shifts", 32'(nshift), 32'd6);
    config_reset = 1'b0;
    word_valid   = 1'b0;
    @(negedge clk);
    check_eq("mid_reset_outs", {26'd0, word_ready, cfg_bit, cfg_shift, busy, done, err}, 32'd0);
    config_reset = 1'b1;
    @(negedge clk);
    check_eq("post_reset_idle", {30'd0, busy, word_ready}, 32'd0);
  endtask

  task automatic run_len1(input bit v);
    int acc, n, nd;
    s1_start = 1'b1;
    s1_ver   = v;
    s1_data  = WW'($urandom);
    s1_valid = 1'b1;
    acc = 0; n = 0; nd = 0;
    for (int t = 0; t < 50 && nd == 0; t++) begin
      @(negedge clk);
      s1_start = 1'b0;
      if (ready1) acc++;
      if (shift1) begin
        n++;
        check_eq("len1_bit", 32'(bit1), 32'(s1_data[0]));
      end
      if (done1) nd++;
    end
    s1_valid = 1'b0;
    check_eq("len1_accepts", 32'(acc), 32'd1);
    check_eq("len1_shifts", 32'(n), 32'(1 + v));
    check_eq("len1_done", 32'(nd), 32'd1);
    check_eq("len1_err", 32'(err1), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    config_reset = 1'b0;
    start = 1'b0; verify_en = 1'b0; word_valid = 1'b0; word_data = '0;
    s1_start = 1'b0; s1_ver = 1'b0; s1_valid = 1'b0; s1_data = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {26'd0, word_ready, cfg_bit, cfg_shift, busy, done, err}, 32'd0);
    check_eq("reset_outs1", {26'd0, ready1, bit1, shift1, busy1, done1, err1}, 32'd0);
    config_reset = 1'b1;
    @(negedge clk);

    run_load(1'b1, 1'b0, 1'b0, 0);
    run_load(1'b1, 1'b1, 1'b0, 0);
    run_load(1'b1, 1'b1, 1'b1, 0);
    run_load(1'b1, 1'b0, 1'b0, 5);
    reset_mid_load();
    run_load(1'b0, 1'b1, 1'b0, 0);
    for (int r = 0; r < 20; r++) begin
      run_load(1'b0, 1'($urandom), 1'($urandom), $urandom_range(0, 4));
    end
    run_len1(1'b0);
    run_len1(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
